data_memory_responder: RTL and testbench

- Memory-side responder for the 8-bit CPU's data-memory interface; the CPU is the initiator and this block is the other end.
- Accepts READ/WRITE requests, holds the CPU off with BUSYWAIT for a fixed access latency, then commits the write or returns read data.
- Internal storage is 2^ADDR_W words of DATA_W bits; the block is instantiated beside CPU in the top level and testbench.

---
 rtl/data_memory_responder.sv | 139 +++++++++++++
 tb/tb_data_memory_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder for the 8-bit CPU. It accepts one READ/WRITE request,
// stalls the CPU with BUSYWAIT for LATENCY cycles, then commits the access.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | waiting; a request raises BUSYWAIT at once and is latched
//   ACCESS | latency countdown; commit on the edge where the counter hits 0
//   DONE   | one BUSYWAIT-low cycle, requests ignored, then back to IDLE
module data_memory_responder #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned LATENCY = 5
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              READ,
   input  logic              WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [DATA_W-1:0] WRITEDATA,
   output logic [DATA_W-1:0] READDATA,
   output logic              BUSYWAIT
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned LOAD_I = (LATENCY > 1) ? (LATENCY - 1) : 0;
   localparam logic [3:0]  LOAD   = LOAD_I[3:0];

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   readdata_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                commit;
   logic                commit_we;
   logic [ADDR_W-1:0]   commit_addr;
   logic [DATA_W-1:0]   commit_data;
   logic                busy;

   // Control state, counter and latched request.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // Next-state, counter load/decrement, commit strobe and BUSYWAIT.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      commit      = 1'b0;
      commit_we   = we_q;
      commit_addr = addr_q;
      commit_data = wdata_q;
      busy        = 1'b0;
      case (state_q)
         IDLE: begin
            if (READ || WRITE) begin
               busy    = 1'b1;
               addr_d  = ADDRESS;
               wdata_d = WRITEDATA;
               // READ and WRITE together are treated as a write.
               we_d    = WRITE;
               if (LATENCY == 1) begin
                  // Single-cycle build commits straight from the request.
                  commit      = 1'b1;
                  commit_we   = WRITE;
                  commit_addr = ADDRESS;
                  commit_data = WRITEDATA;
                  state_d     = DONE;
               end else begin
                  cnt_d   = LOAD;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            busy  = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = '0;
               commit  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Storage: cleared on reset, written on a write commit.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit && commit_we) begin
         mem_q[commit_addr] <= commit_data;
      end
   end

   // Read data register: only a read commit updates it.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         readdata_q <= '0;
      end else if (commit && !commit_we) begin
         readdata_q <= mem_q[commit_addr];
      end
   end

   assign READDATA = readdata_q;
   assign BUSYWAIT = busy;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=5 instance and a
// LATENCY=1 instance sharing clock and reset.
module tb_data_memory_responder;

   logic       CLOCK;
   logic       RESET;
   logic       READ, WRITE;
   logic [7:0] ADDRESS, WRITEDATA;
   logic [7:0] READDATA;
   logic       BUSYWAIT;

   logic       r1, w1;
   logic [7:0] a1, d1;
   logic [7:0] rd1;
   logic       busy1;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;

   data_memory_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(5)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .READ      (READ),
      .WRITE     (WRITE),
      .ADDRESS   (ADDRESS),
      .WRITEDATA (WRITEDATA),
      .READDATA  (READDATA),
      .BUSYWAIT  (BUSYWAIT)
   );

   data_memory_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .READ      (r1),
      .WRITE     (w1),
      .ADDRESS   (a1),
      .WRITEDATA (d1),
      .READDATA  (rd1),
      .BUSYWAIT  (busy1)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLOCK);
      #1;
   endtask

   // Presents a request, counts BUSYWAIT-high cycles and returns in the DONE
   // cycle. Optionally changes ADDRESS/WRITEDATA after chg_at busy cycles,
   // and optionally keeps the request asserted through DONE.
   task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input int chg_at,
                         input logic [7:0] chg_a, input logic [7:0] chg_d,
                         input logic hold, output int busy_cycles);
      READ      = rd;
      WRITE     = wr;
      ADDRESS   = a;
      WRITEDATA = d;
      busy_cycles = 0;
      #1;
      while (BUSYWAIT && busy_cycles < 40) begin
         busy_cycles++;
         if (busy_cycles == chg_at) begin
            ADDRESS   = chg_a;
            WRITEDATA = chg_d;
         end
         @(posedge CLOCK);
         #2;
      end
      if (!hold) begin
         READ  = 1'b0;
         WRITE = 1'b0;
      end
   endtask

   initial begin
      RESET = 1'b1;
      READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
      r1 = 1'b0; w1 = 1'b0; a1 = 8'h00; d1 = 8'h00;

      // Reset for two edges, then idle for ten cycles.
      next_cycle();
      next_cycle();
      RESET = 1'b0;
      #1;
      for (int i = 0; i < 10; i++) begin
         check("idle_busy", {31'd0, BUSYWAIT}, 32'd0);
         check("idle_rdata", {24'd0, READDATA}, 32'h00);
         next_cycle();
      end

      // Write 0x5C to 0x2A, then read it back.
      access(1'b0, 1'b1, 8'h2A, 8'h5C, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("wr2a_stall", cyc, 5);
      check("wr2a_rdata_unchanged", {24'd0, READDATA}, 32'h00);
      next_cycle();
      access(1'b1, 1'b0, 8'h2A, 8'h00, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("rd2a_stall", cyc, 5);
      check("rd2a_data", {24'd0, READDATA}, 32'h5C);

      // READ and WRITE together at the top address: a write only.
      next_cycle();
      access(1'b1, 1'b1, 8'hFF, 8'hA5, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("rw_stall", cyc, 5);
      check("rw_rdata_held", {24'd0, READDATA}, 32'h5C);
      next_cycle();
      access(1'b1, 1'b0, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("rdff_stall", cyc, 5);
      check("rdff_data", {24'd0, READDATA}, 32'hA5);

      // Inputs changed during ACCESS are ignored.
      next_cycle();
      access(1'b0, 1'b1, 8'h10, 8'h11, 2, 8'h20, 8'hFF, 1'b0, cyc);
      check("chg_stall", cyc, 5);
      check("chg_rdata_unchanged", {24'd0, READDATA}, 32'hA5);
      next_cycle();
      access(1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("rd10_data", {24'd0, READDATA}, 32'h11);
      next_cycle();
      access(1'b1, 1'b0, 8'h20, 8'h00, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("rd20_data", {24'd0, READDATA}, 32'h00);

      // Reset during a write aborts it and clears storage.
      next_cycle();
      access(1'b0, 1'b1, 8'h03, 8'h99, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("wr03_stall", cyc, 5);
      next_cycle();
      READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h03; WRITEDATA = 8'h77;
      #1;
      check("rst_busy_c1", {31'd0, BUSYWAIT}, 32'd1);
      next_cycle();
      check("rst_busy_c2", {31'd0, BUSYWAIT}, 32'd1);
      next_cycle();
      check("rst_busy_c3", {31'd0, BUSYWAIT}, 32'd1);
      RESET = 1'b1;
      WRITE = 1'b0;
      next_cycle();
      RESET = 1'b0;
      #1;
      check("rst_busy_after", {31'd0, BUSYWAIT}, 32'd0);
      next_cycle();
      access(1'b1, 1'b0, 8'h03, 8'h00, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("rd03_stall", cyc, 5);
      check("rd03_data", {24'd0, READDATA}, 32'h00);
      next_cycle();
      access(1'b1, 1'b0, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("rdff_cleared", {24'd0, READDATA}, 32'h00);

      // Back-to-back: request held through DONE, accepted fresh in next IDLE.
      next_cycle();
      access(1'b0, 1'b1, 8'h40, 8'hC3, 0, 8'h00, 8'h00, 1'b0, cyc);
      next_cycle();
      access(1'b1, 1'b0, 8'h40, 8'h00, 0, 8'h00, 8'h00, 1'b1, cyc);
      check("b2b_first_stall", cyc, 5);
      check("b2b_done_busy", {31'd0, BUSYWAIT}, 32'd0);
      check("b2b_first_data", {24'd0, READDATA}, 32'hC3);
      next_cycle();
      access(1'b1, 1'b0, 8'h2A, 8'h00, 0, 8'h00, 8'h00, 1'b0, cyc);
      check("b2b_second_stall", cyc, 5);
      check("b2b_second_data", {24'd0, READDATA}, 32'h00);

      // LATENCY=1 instance: one busy cycle, one DONE cycle per access.
      next_cycle();
      w1 = 1'b1; a1 = 8'h05; d1 = 8'h3C;
      #1;
      check("l1_wr_busy", {31'd0, busy1}, 32'd1);
      next_cycle();
      check("l1_wr_done", {31'd0, busy1}, 32'd0);
      check("l1_wr_rdata", {24'd0, rd1}, 32'h00);
      w1 = 1'b0;
      next_cycle();
      check("l1_idle", {31'd0, busy1}, 32'd0);
      r1 = 1'b1; a1 = 8'h05;
      #1;
      check("l1_rd_busy", {31'd0, busy1}, 32'd1);
      next_cycle();
      check("l1_rd_done", {31'd0, busy1}, 32'd0);
      check("l1_rd_data", {24'd0, rd1}, 32'h3C);
      next_cycle();
      check("l1_rd_again_busy", {31'd0, busy1}, 32'd1);
      next_cycle();
      check("l1_rd_again_done", {31'd0, busy1}, 32'd0);
      r1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
